// File: rtl/or1200_if_prefetch.sv
// Instruction-fetch prefetch stage: issues sequential fetches on the instruction bus,
// buffers the returned words in a small FIFO and presents the head entry to decode.
module or1200_if_prefetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0100,
    parameter logic [31:0] NOP_INSN = 32'h1541_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     icpu_req_o,
    output logic [31:0]              icpu_adr_o,
    input  logic [31:0]              icpu_dat_i,
    input  logic                     icpu_ack_i,
    input  logic                     icpu_err_i,
    input  logic                     redir_i,
    input  logic [31:0]              redir_pc_i,
    input  logic                     id_freeze,
    output logic [31:0]              if_insn,
    output logic [31:0]              if_pc,
    output logic                     if_valid,
    output logic                     if_stall,
    output logic                     except_ibuserr,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        err;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    entry_t             wr_entry;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level, level_next;
    logic [31:0]        fetch_pc, fetch_pc_next, adr_next;
    logic               discard, discard_next;
    logic               halted, halted_next;
    logic               req_next;
    logic               resp, push, pop, hold;

    // Responses only count while a request is actually on the bus.
    assign resp = icpu_req_o & (icpu_ack_i | icpu_err_i);
    assign push = resp & ~discard & ~redir_i;
    assign pop  = if_valid & ~id_freeze & ~redir_i;
    assign hold = icpu_req_o & ~(icpu_ack_i | icpu_err_i);

    assign wr_entry.insn = icpu_err_i ? NOP_INSN : icpu_dat_i;
    assign wr_entry.pc   = icpu_adr_o;
    assign wr_entry.err  = icpu_err_i;

    // NOTE: every signal driven here gets a default first, so no path can leave
    // a value unassigned and infer a latch.
    always_comb begin
        level_next    = level;
        halted_next   = halted;
        fetch_pc_next = fetch_pc;
        discard_next  = 1'b0;
        req_next      = 1'b0;
        adr_next      = icpu_adr_o;

        if (redir_i) begin
            level_next    = '0;
            halted_next   = 1'b0;
            fetch_pc_next = redir_pc_i & ~32'h3;
        end else begin
            case ({push, pop})
                2'b10:   level_next = level + LVL_W'(1);
                2'b01:   level_next = level - LVL_W'(1);
                default: level_next = level;
            endcase
            if (push && icpu_err_i)
                halted_next = 1'b1;
            else if (push)
                fetch_pc_next = fetch_pc + 32'd4;
        end

        // An outstanding request survives a redirect; its response is tagged for discard.
        if (hold) begin
            discard_next = discard | redir_i;
            req_next     = 1'b1;
            adr_next     = icpu_adr_o;
        end else begin
            req_next = ~halted_next & (level_next < LVL_W'(DEPTH));
            adr_next = fetch_pc_next;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            icpu_req_o <= 1'b0;
            icpu_adr_o <= RESET_PC;
            fetch_pc   <= RESET_PC;
            discard    <= 1'b0;
            halted     <= 1'b0;
            level      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            icpu_req_o <= req_next;
            icpu_adr_o <= adr_next;
            fetch_pc   <= fetch_pc_next;
            discard    <= discard_next;
            halted     <= halted_next;
            level      <= level_next;
            if (redir_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: the FIFO storage is not reset; the level counter gates every read,
    // so stale contents can never reach the outputs.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_entry;
    end

    assign head           = mem[rd_ptr];
    assign if_valid       = (level != '0);
    assign if_insn        = if_valid ? head.insn : NOP_INSN;
    assign if_pc          = if_valid ? head.pc : 32'h0;
    assign except_ibuserr = if_valid & head.err;
    assign if_stall       = (level == '0) & ~halted;
    assign fifo_level     = level;

endmodule

// File: tb/tb_or1200_if_prefetch.sv
// Directed self-checking bench for or1200_if_prefetch with a hand-driven instruction bus.
module tb_or1200_if_prefetch;

    localparam logic [31:0] NOP = 32'h1541_0000;

    logic        clk;
    logic        rst;
    logic        icpu_req_o;
    logic [31:0] icpu_adr_o;
    logic [31:0] icpu_dat_i;
    logic        icpu_ack_i;
    logic        icpu_err_i;
    logic        redir_i;
    logic [31:0] redir_pc_i;
    logic        id_freeze;
    logic [31:0] if_insn;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_stall;
    logic        except_ibuserr;
    logic [1:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    or1200_if_prefetch #(.DEPTH(2), .RESET_PC(32'h0000_0100), .NOP_INSN(NOP)) dut (
        .clk(clk), .rst(rst),
        .icpu_req_o(icpu_req_o), .icpu_adr_o(icpu_adr_o), .icpu_dat_i(icpu_dat_i),
        .icpu_ack_i(icpu_ack_i), .icpu_err_i(icpu_err_i),
        .redir_i(redir_i), .redir_pc_i(redir_pc_i), .id_freeze(id_freeze),
        .if_insn(if_insn), .if_pc(if_pc), .if_valid(if_valid), .if_stall(if_stall),
        .except_ibuserr(except_ibuserr), .fifo_level(fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic ack, input logic err, input logic [31:0] a);
        icpu_ack_i = ack;
        icpu_err_i = err;
        icpu_dat_i = mem_word(a);
    endtask

    task automatic test_reset;
        rst = 1'b0; redir_i = 1'b0; redir_pc_i = '0; id_freeze = 1'b0;
        bus(1'b0, 1'b0, 32'h0);
        repeat (2) tick();
        checks++; if (icpu_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", icpu_req_o); end
        checks++; if (icpu_adr_o !== 32'h100) begin errors++; $display("FAIL reset_adr: got %h want 00000100", icpu_adr_o); end
        checks++; if (fifo_level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        checks++; if (if_insn !== NOP) begin errors++; $display("FAIL reset_insn: got %h want %h", if_insn, NOP); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc); end
        checks++; if (except_ibuserr !== 1'b0) begin errors++; $display("FAIL reset_buserr: got %b want 0", except_ibuserr); end
        checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", if_stall); end
        rst = 1'b1;
        tick();
        checks++; if (icpu_req_o !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", icpu_req_o); end
        checks++; if (icpu_adr_o !== 32'h100) begin errors++; $display("FAIL first_adr: got %h want 00000100", icpu_adr_o); end
    endtask

    task automatic test_stream;
        for (int k = 1; k <= 3; k++) begin
            logic [31:0] pc;
            pc = 32'h100 + 32'(4 * (k - 1));
            bus(1'b1, 1'b0, pc);
            tick();
            checks++; if (icpu_adr_o !== pc + 32'd4) begin errors++; $display("FAIL stream_adr%0d: got %h want %h", k, icpu_adr_o, pc + 32'd4); end
            checks++; if (icpu_req_o !== 1'b1) begin errors++; $display("FAIL stream_req%0d: got %b want 1", k, icpu_req_o); end
            checks++; if (if_pc !== pc) begin errors++; $display("FAIL stream_pc%0d: got %h want %h", k, if_pc, pc); end
            checks++; if (if_insn !== mem_word(pc)) begin errors++; $display("FAIL stream_insn%0d: got %h want %h", k, if_insn, mem_word(pc)); end
            checks++; if (fifo_level !== 2'd1) begin errors++; $display("FAIL stream_level%0d: got %0d want 1", k, fifo_level); end
        end
    endtask

    task automatic test_redirect_outstanding;
        bus(1'b0, 1'b0, 32'h0);
        redir_i = 1'b1; redir_pc_i = 32'h2000;
        tick();
        redir_i = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b want 0", if_valid); end
        checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL redir_flush_stall: got %b want 1", if_stall); end
        checks++; if (icpu_adr_o !== 32'h10C) begin errors++; $display("FAIL redir_hold_adr: got %h want 0000010c", icpu_adr_o); end
        tick();
        checks++; if (icpu_req_o !== 1'b1) begin errors++; $display("FAIL redir_hold_req: got %b want 1", icpu_req_o); end
        checks++; if (icpu_adr_o !== 32'h10C) begin errors++; $display("FAIL redir_hold_adr2: got %h want 0000010c", icpu_adr_o); end
        bus(1'b1, 1'b0, 32'h10C);
        tick();
        checks++; if (fifo_level !== 2'd0) begin errors++; $display("FAIL redir_drop_level: got %0d want 0", fifo_level); end
        checks++; if (icpu_adr_o !== 32'h2000) begin errors++; $display("FAIL redir_new_adr: got %h want 00002000", icpu_adr_o); end
        checks++; if (icpu_req_o !== 1'b1) begin errors++; $display("FAIL redir_new_req: got %b want 1", icpu_req_o); end
        bus(1'b1, 1'b0, 32'h2000);
        tick();
        checks++; if (if_pc !== 32'h2000) begin errors++; $display("FAIL redir_first_pc: got %h want 00002000", if_pc); end
        checks++; if (if_insn !== mem_word(32'h2000)) begin errors++; $display("FAIL redir_first_insn: got %h want %h", if_insn, mem_word(32'h2000)); end
        checks++; if (icpu_adr_o !== 32'h2004) begin errors++; $display("FAIL redir_next_adr: got %h want 00002004", icpu_adr_o); end
    endtask

    task automatic test_freeze;
        id_freeze = 1'b1;
        bus(1'b1, 1'b0, 32'h2004);
        tick();
        checks++; if (fifo_level !== 2'd2) begin errors++; $display("FAIL freeze_level: got %0d want 2", fifo_level); end
        checks++; if (icpu_req_o !== 1'b0) begin errors++; $display("FAIL freeze_req_drop: got %b want 0", icpu_req_o); end
        checks++; if (if_pc !== 32'h2000) begin errors++; $display("FAIL freeze_head: got %h want 00002000", if_pc); end
        bus(1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (icpu_req_o !== 1'b0) begin errors++; $display("FAIL freeze_req_low: got %b want 0", icpu_req_o); end
        checks++; if (fifo_level !== 2'd2) begin errors++; $display("FAIL freeze_level_hold: got %0d want 2", fifo_level); end
        id_freeze = 1'b0;
        tick();
        checks++; if (icpu_req_o !== 1'b1) begin errors++; $display("FAIL unfreeze_req: got %b want 1", icpu_req_o); end
        checks++; if (icpu_adr_o !== 32'h2008) begin errors++; $display("FAIL unfreeze_adr: got %h want 00002008", icpu_adr_o); end
        checks++; if (if_pc !== 32'h2004) begin errors++; $display("FAIL unfreeze_pc: got %h want 00002004", if_pc); end
        checks++; if (if_insn !== mem_word(32'h2004)) begin errors++; $display("FAIL unfreeze_insn: got %h want %h", if_insn, mem_word(32'h2004)); end
        bus(1'b1, 1'b0, 32'h2008);
        tick();
        checks++; if (if_pc !== 32'h2008) begin errors++; $display("FAIL unfreeze_pc2: got %h want 00002008", if_pc); end
        checks++; if (fifo_level !== 2'd1) begin errors++; $display("FAIL unfreeze_level: got %0d want 1", fifo_level); end
    endtask

    task automatic test_redirect_coincident;
        bus(1'b1, 1'b0, 32'h200C);
        redir_i = 1'b1; redir_pc_i = 32'h10B;
        tick();
        redir_i = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL coinc_valid: got %b want 0", if_valid); end
        checks++; if (if_insn !== NOP) begin errors++; $display("FAIL coinc_insn: got %h want %h", if_insn, NOP); end
        checks++; if (fifo_level !== 2'd0) begin errors++; $display("FAIL coinc_level: got %0d want 0", fifo_level); end
        checks++; if (icpu_req_o !== 1'b1) begin errors++; $display("FAIL coinc_req: got %b want 1", icpu_req_o); end
        checks++; if (icpu_adr_o !== 32'h108) begin errors++; $display("FAIL coinc_adr: got %h want 00000108", icpu_adr_o); end
    endtask

    task automatic test_bus_error;
        bus(1'b1, 1'b0, 32'h108);
        tick();
        bus(1'b1, 1'b0, 32'h10C);
        tick();
        checks++; if (icpu_adr_o !== 32'h110) begin errors++; $display("FAIL err_pre_adr: got %h want 00000110", icpu_adr_o); end
        bus(1'b0, 1'b1, 32'hBEEF);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        checks++; if (except_ibuserr !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", except_ibuserr); end
        checks++; if (if_insn !== NOP) begin errors++; $display("FAIL err_insn: got %h want %h", if_insn, NOP); end
        checks++; if (if_pc !== 32'h110) begin errors++; $display("FAIL err_pc: got %h want 00000110", if_pc); end
        checks++; if (icpu_req_o !== 1'b0) begin errors++; $display("FAIL err_req: got %b want 0", icpu_req_o); end
        checks++; if (if_stall !== 1'b0) begin errors++; $display("FAIL err_stall: got %b want 0", if_stall); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL halt_valid: got %b want 0", if_valid); end
        checks++; if (if_stall !== 1'b0) begin errors++; $display("FAIL halt_stall: got %b want 0", if_stall); end
        tick();
        checks++; if (icpu_req_o !== 1'b0) begin errors++; $display("FAIL halt_req: got %b want 0", icpu_req_o); end
        redir_i = 1'b1; redir_pc_i = 32'h603;
        tick();
        redir_i = 1'b0;
        checks++; if (icpu_req_o !== 1'b1) begin errors++; $display("FAIL resume_req: got %b want 1", icpu_req_o); end
        checks++; if (icpu_adr_o !== 32'h600) begin errors++; $display("FAIL resume_adr: got %h want 00000600", icpu_adr_o); end
        checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL resume_stall: got %b want 1", if_stall); end
        bus(1'b1, 1'b0, 32'h600);
        tick();
        checks++; if (if_pc !== 32'h600) begin errors++; $display("FAIL resume_pc: got %h want 00000600", if_pc); end
        checks++; if (except_ibuserr !== 1'b0) begin errors++; $display("FAIL resume_buserr: got %b want 0", except_ibuserr); end
    endtask

    task automatic test_async_reset;
        bus(1'b1, 1'b0, 32'h604);
        tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (icpu_req_o !== 1'b0) begin errors++; $display("FAIL areset_req: got %b want 0", icpu_req_o); end
        checks++; if (icpu_adr_o !== 32'h100) begin errors++; $display("FAIL areset_adr: got %h want 00000100", icpu_adr_o); end
        checks++; if (fifo_level !== 2'd0) begin errors++; $display("FAIL areset_level: got %0d want 0", fifo_level); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", if_valid); end
        checks++; if (if_insn !== NOP) begin errors++; $display("FAIL areset_insn: got %h want %h", if_insn, NOP); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL areset_pc: got %h want 0", if_pc); end
        checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL areset_stall: got %b want 1", if_stall); end
        bus(1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        checks++; if (icpu_req_o !== 1'b1) begin errors++; $display("FAIL restart_req: got %b want 1", icpu_req_o); end
        checks++; if (icpu_adr_o !== 32'h100) begin errors++; $display("FAIL restart_adr: got %h want 00000100", icpu_adr_o); end
        bus(1'b1, 1'b0, 32'h100);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        checks++; if (if_pc !== 32'h100) begin errors++; $display("FAIL restart_pc: got %h want 00000100", if_pc); end
        checks++; if (icpu_adr_o !== 32'h104) begin errors++; $display("FAIL restart_next_adr: got %h want 00000104", icpu_adr_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_redirect_outstanding();
        test_freeze();
        test_redirect_coincident();
        test_bus_error();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
